// File: rtl/sobel_enhance_param.sv
// Streamed 3x3 Sobel edge/enhance/threshold on luma, two line buffers feeding the window.
// Latency 5 clk for pixels and syncs alike; no backpressure, output follows input timing.
module sobel_enhance_param #(
    parameter int DW        = 8,
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          per_frame_vsync,
    input  logic          per_frame_href,
    input  logic          per_frame_clken,
    input  logic [DW-1:0] per_img_Y,
    input  logic [1:0]    mode,
    input  logic [1:0]    edge_shift,
    input  logic [DW-1:0] thresh,
    output logic          post_frame_vsync,
    output logic          post_frame_href,
    output logic          post_frame_clken,
    output logic [DW-1:0] post_img_Y,
    output logic          post_img_bit
);
    localparam int CW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int RW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam int MW = DW + 3;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP - 1);
    localparam logic [MW-1:0] PIX_MAX = MW'((1 << DW) - 1);

    typedef enum logic {WAIT_FRAME = 1'b0, ACTIVE = 1'b1} state_t;
    state_t state;

    logic          vs_low_q, href_q, line_full;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    mode_q, shift_q;
    logic [DW-1:0] thresh_q;
    logic [3:0]    vs_sr, hr_sr, ck_sr;
    logic          vs_rise, href_fall, pix, frame_on;

    // vs_low_q resets to 0, so a frame already in flight at reset release is not mistaken for a new one
    assign vs_rise   = per_frame_vsync & vs_low_q;
    assign href_fall = href_q & ~per_frame_href;
    assign pix       = per_frame_href & per_frame_clken;
    assign frame_on  = (state == ACTIVE) | vs_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_FRAME;
            vs_low_q  <= 1'b0;
            href_q    <= 1'b0;
            col       <= '0;
            line_full <= 1'b0;
            row       <= '0;
            mode_q    <= 2'b00;
            shift_q   <= 2'b00;
            thresh_q  <= '0;
            vs_sr     <= '0;
            hr_sr     <= '0;
            ck_sr     <= '0;
        end else begin
            vs_low_q <= ~per_frame_vsync;
            href_q   <= per_frame_href;
            case (state)
                WAIT_FRAME: if (vs_rise) state <= ACTIVE;
                ACTIVE:     if (!per_frame_vsync) state <= WAIT_FRAME;
                default:    state <= WAIT_FRAME;
            endcase
            if (vs_rise) begin
                mode_q   <= mode;
                shift_q  <= edge_shift;
                thresh_q <= thresh;
            end
            if (vs_rise)
                row <= '0;
            else if (href_fall && row != ROW_MAX)
                row <= row + 1'b1;
            if (href_fall) begin
                col       <= '0;
                line_full <= 1'b0;
            end else if (pix && !line_full) begin
                if (col == COL_MAX) line_full <= 1'b1;
                else                col       <= col + 1'b1;
            end
            vs_sr <= {vs_sr[2:0], per_frame_vsync & frame_on};
            hr_sr <= {hr_sr[2:0], per_frame_href  & frame_on};
            ck_sr <= {ck_sr[2:0], per_frame_clken & frame_on};
        end
    end

    // lb0 holds the previous line, lb1 the one before it
    logic [DW-1:0] lb0 [IMG_HDISP];
    logic [DW-1:0] lb1 [IMG_HDISP];

    always_ff @(posedge clk) begin
        if (pix && !line_full) begin
            lb0[col] <= per_img_Y;
            lb1[col] <= lb0[col];
        end
    end

    logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic          zero1, pass1;

    always_ff @(posedge clk) begin
        if (rst) begin
            {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
            zero1 <= 1'b0;
            pass1 <= 1'b0;
        end else if (pix) begin
            p11 <= p12; p12 <= p13; p13 <= lb1[col];
            p21 <= p22; p22 <= p23; p23 <= lb0[col];
            p31 <= p32; p32 <= p33; p33 <= per_img_Y;
            zero1 <= (row == '0) || (col == '0);
            pass1 <= (row == RW'(1)) || (col == CW'(1));
        end
    end

    logic [MW-1:0]        gx_pos, gx_neg, gy_pos, gy_neg, ax, ay, mag3;
    logic signed [MW-1:0] gx2, gy2;
    logic [DW-1:0]        c2, c3, y_n, y4;
    logic                 zero2, pass2, zero3, pass3, hit, b_n, b4;
    logic [MW:0]          enh;

    always_comb begin
        gx_pos = MW'(p13) + (MW'(p23) << 1) + MW'(p33);
        gx_neg = MW'(p11) + (MW'(p21) << 1) + MW'(p31);
        gy_pos = MW'(p11) + (MW'(p12) << 1) + MW'(p13);
        gy_neg = MW'(p31) + (MW'(p32) << 1) + MW'(p33);
        ax     = gx2[MW-1] ? $unsigned(-gx2) : $unsigned(gx2);
        ay     = gy2[MW-1] ? $unsigned(-gy2) : $unsigned(gy2);
    end

    always_comb begin
        hit = mag3 >= MW'(thresh_q);
        enh = (MW+1)'(c3) + (MW+1)'(mag3 >> shift_q);
        case (mode_q)
            2'b00:   y_n = c3;
            2'b01:   y_n = (mag3 > PIX_MAX) ? '1 : mag3[DW-1:0];
            2'b10:   y_n = (enh > (MW+1)'(PIX_MAX)) ? '1 : enh[DW-1:0];
            default: y_n = hit ? '1 : '0;
        endcase
        b_n = hit;
        if (pass3) y_n = c3;
        if (zero3) begin
            y_n = '0;
            b_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gx2 <= '0; gy2 <= '0; c2 <= '0; zero2 <= 1'b0; pass2 <= 1'b0;
            mag3 <= '0; c3 <= '0; zero3 <= 1'b0; pass3 <= 1'b0;
            y4 <= '0; b4 <= 1'b0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Y       <= '0;
            post_img_bit     <= 1'b0;
        end else begin
            gx2   <= $signed(gx_pos - gx_neg);
            gy2   <= $signed(gy_pos - gy_neg);
            c2    <= p22;
            zero2 <= zero1;
            pass2 <= pass1;
            mag3  <= pass2 ? '0 : ax + ay;
            c3    <= c2;
            zero3 <= zero2;
            pass3 <= pass2;
            y4    <= y_n;
            b4    <= b_n;
            post_frame_vsync <= vs_sr[3];
            post_frame_href  <= hr_sr[3];
            post_frame_clken <= ck_sr[3] & (state == ACTIVE);
            if (hr_sr[3] && state == ACTIVE) begin
                post_img_Y   <= y4;
                post_img_bit <= b4;
            end else begin
                post_img_Y   <= '0;
                post_img_bit <= 1'b0;
            end
        end
    end
endmodule
